vga_timing_1440x900: RTL and testbench

- Generates raster timing for the 1440x900@60 Hz display (pixel clock 106.47 MHz):
  - curr_x/curr_y pixel counters, which feed the sprite/background compositor;
  - a per-frame tick for the sprite-position logic.
- Also owns the VGA pin stage:
  - registers the compositor's draw_r/g/b;
  - forces black outside the active area;
  - delays hsync/vsync so they stay aligned with the compositor's registered colour path.

---
 rtl/vga_timing_1440x900.sv | 129 ++++++++++++
 tb/tb_vga_timing_1440x900.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_1440x900.sv
// Raster timing for 1440x900@60 plus the VGA pin stage. Blanking and syncs are delayed
// through a PIPE_DLY-deep shift register so they reach the pins with the compositor's colour.
module vga_timing_1440x900 #(
  parameter int unsigned H_ACTIVE = 1440,
  parameter int unsigned H_FP     = 80,
  parameter int unsigned H_SYNC   = 152,
  parameter int unsigned H_BP     = 232,
  parameter int unsigned V_ACTIVE = 900,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BP     = 28,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b1,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] curr_x,
  output logic [10:0] curr_y,
  output logic        frame_tick,
  input  logic [3:0]  draw_r,
  input  logic [3:0]  draw_g,
  input  logic [3:0]  draw_b,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] HLast    = 11'(H_TOTAL - 1);
  localparam logic [10:0] VLast    = 11'(V_TOTAL - 1);
  localparam logic [10:0] HActEnd  = 11'(H_ACTIVE);
  localparam logic [10:0] VActEnd  = 11'(V_ACTIVE);
  localparam logic [10:0] HSyncBeg = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HSyncEnd = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VSyncBeg = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VSyncEnd = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        tick_q, tick_d;

  logic        act_raw, hs_raw, vs_raw;
  logic [PIPE_DLY-1:0] act_q, hs_q, vs_q;

  logic [3:0]  r_q, g_q, b_q;
  logic        hs_pin_q, vs_pin_q;

  // Raster counters
  always_comb begin
    x_d = x_q + 11'd1;
    y_d = y_q;
    if (x_q == HLast) begin
      x_d = '0;
      y_d = (y_q == VLast) ? '0 : y_q + 11'd1;
    end
  end

  // Next state is (0,0) only on the frame wrap, so the tick lines up with that presentation.
  assign tick_d = (x_d == '0) && (y_d == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q    <= '0;
      y_q    <= '0;
      tick_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      tick_q <= tick_d;
    end
  end

  // Raw decode of the current raster position
  always_comb begin
    act_raw = (x_q < HActEnd) && (y_q < VActEnd);
    hs_raw  = (x_q >= HSyncBeg) && (x_q < HSyncEnd);
    vs_raw  = (y_q >= VSyncBeg) && (y_q < VSyncEnd);
  end

  // Alignment delay: matches the compositor's latency from curr_x/curr_y to draw_*.
  always_ff @(posedge clk) begin
    if (!rst) begin
      act_q <= '0;
      hs_q  <= '0;
      vs_q  <= '0;
    end else begin
      act_q[0] <= act_raw;
      hs_q[0]  <= hs_raw;
      vs_q[0]  <= vs_raw;
      for (int i = 1; i < int'(PIPE_DLY); i++) begin
        act_q[i] <= act_q[i-1];
        hs_q[i]  <= hs_q[i-1];
        vs_q[i]  <= vs_q[i-1];
      end
    end
  end

  // Pin stage; the colour register doubles as the single draw_* capture.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_q      <= 4'h0;
      g_q      <= 4'h0;
      b_q      <= 4'h0;
      hs_pin_q <= ~H_POL;
      vs_pin_q <= ~V_POL;
    end else begin
      r_q      <= act_q[PIPE_DLY-1] ? draw_r : 4'h0;
      g_q      <= act_q[PIPE_DLY-1] ? draw_g : 4'h0;
      b_q      <= act_q[PIPE_DLY-1] ? draw_b : 4'h0;
      hs_pin_q <= hs_q[PIPE_DLY-1] ? H_POL : ~H_POL;
      vs_pin_q <= vs_q[PIPE_DLY-1] ? V_POL : ~V_POL;
    end
  end

  assign curr_x     = x_q;
  assign curr_y     = y_q;
  assign frame_tick = tick_q;
  assign vga_r      = r_q;
  assign vga_g      = g_q;
  assign vga_b      = b_q;
  assign vga_hs     = hs_pin_q;
  assign vga_vs     = vs_pin_q;

endmodule

// File: tb/tb_vga_timing_1440x900.sv
// Bench for vga_timing_1440x900: default timing plus two small-raster instances
// (PIPE_DLY 1 and 3), each tracked by a reference raster model and a pin scoreboard.
module tb_vga_timing_1440x900;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pins_t;

  typedef struct {
    logic       rst;
    int         x;
    int         y;
    logic       hs;
    logic       vs;
    logic [3:0] rgb;
  } vec_t;

  localparam int H_T0 = 1440 + 80 + 152 + 232;
  localparam int V_T0 = 900 + 1 + 3 + 28;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic align = 1'b0;
  logic [3:0] comp_r;

  logic [10:0] cx [3];
  logic [10:0] cy [3];
  logic        tk [3];
  logic [3:0]  dr [3];
  logic [3:0]  vr [3];
  logic [3:0]  vg [3];
  logic [3:0]  vb [3];
  logic        hsv [3];
  logic        vsv [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Compositor stand-in with one clock of latency
  always_ff @(posedge clk) comp_r <= cx[0][3:0];

  task automatic check(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s dut%0d got %0h want %0h at %0t", name, inst, got, want, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int HA = (g == 0) ? 1440 : 8;
    localparam int HF = (g == 0) ? 80   : 2;
    localparam int HS = (g == 0) ? 152  : 2;
    localparam int HB = (g == 0) ? 232  : 2;
    localparam int VA = (g == 0) ? 900  : 4;
    localparam int VF = 1;
    localparam int VS = (g == 0) ? 3    : 1;
    localparam int VB = (g == 0) ? 28   : 1;
    localparam int PD = (g == 2) ? 3    : 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    if (g == 0) begin : g_comp
      assign dr[g] = align ? comp_r : 4'hF;
    end else begin : g_flat
      assign dr[g] = 4'hF;
    end

    vga_timing_1440x900 #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .H_POL(1'b0), .V_POL(1'b1), .PIPE_DLY(PD)
    ) u_dut (
      .clk(clk), .rst(rst), .curr_x(cx[g]), .curr_y(cy[g]), .frame_tick(tk[g]),
      .draw_r(dr[g]), .draw_g(4'hF), .draw_b(4'hF),
      .vga_r(vr[g]), .vga_g(vg[g]), .vga_b(vb[g]), .vga_hs(hsv[g]), .vga_vs(vsv[g])
    );

    function automatic pins_t exp_pins(input int x, input int y);
      pins_t p;
      logic  act;
      act  = (x < HA) && (y < VA);
      p.hs = ((x >= HA + HF) && (x < HA + HF + HS)) ? 1'b0 : 1'b1;
      p.vs = ((y >= VA + VF) && (y < VA + VF + VS)) ? 1'b1 : 1'b0;
      p.r  = !act ? 4'h0 : ((g == 0) && align) ? 4'(x) : 4'hF;
      p.g  = act ? 4'hF : 4'h0;
      p.b  = act ? 4'hF : 4'h0;
      return p;
    endfunction

    // Reference raster + pin scoreboard; state represents the DUT after the last edge.
    initial begin
      int    mx, my;
      logic  mtick;
      pins_t pin_exp, pin_got, idle;
      pins_t q[$];
      idle    = '{hs: 1'b1, vs: 1'b0, r: 4'h0, g: 4'h0, b: 4'h0};
      mx      = 0;
      my      = 0;
      mtick   = 1'b0;
      pin_exp = idle;
      for (int i = 0; i < PD; i++) q.push_back(idle);
      forever begin
        @(negedge clk);
        pin_got = {hsv[g], vsv[g], vr[g], vg[g], vb[g]};
        check("curr_x", g, 32'(cx[g]), 32'(mx));
        check("curr_y", g, 32'(cy[g]), 32'(my));
        check("frame_tick", g, 32'(tk[g]), 32'(mtick));
        check("pins", g, 32'(pin_got), 32'(pin_exp));
        if (!rst) begin
          mx      = 0;
          my      = 0;
          mtick   = 1'b0;
          pin_exp = idle;
          q.delete();
          for (int i = 0; i < PD; i++) q.push_back(idle);
        end else begin
          pin_exp = q.pop_front();
          q.push_back(exp_pins(mx, my));
          mx++;
          if (mx == HT) begin
            mx = 0;
            my = (my == VT - 1) ? 0 : my + 1;
          end
          mtick = (mx == 0) && (my == 0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Small-raster sync placement and width, measured from pin edges.
  task automatic measure_small(input int g, input int hs_x, input int vs_x, input int vs_y,
                               input int vs_w);
    logic ph, pv;
    int   hfall_x, hw, vrise_x, vrise_y, vw;
    bit   hseen, hdone, vseen, vdone;
    hfall_x = -1; hw = 0; vrise_x = -1; vrise_y = -1; vw = 0;
    hseen = 0; hdone = 0; vseen = 0; vdone = 0;
    ph = hsv[g];
    pv = vsv[g];
    for (int i = 0; i < 400 && !(hdone && vdone); i++) begin
      step();
      if (!hseen && ph && !hsv[g]) begin hseen = 1; hfall_x = int'(cx[g]); end
      if (hseen && !hdone) begin
        if (!hsv[g]) hw++;
        else hdone = 1;
      end
      if (!vseen && !pv && vsv[g]) begin
        vseen = 1; vrise_x = int'(cx[g]); vrise_y = int'(cy[g]);
      end
      if (vseen && !vdone) begin
        if (vsv[g]) vw++;
        else vdone = 1;
      end
      ph = hsv[g];
      pv = vsv[g];
    end
    check("hs_fall_x", g, hfall_x, hs_x);
    check("hs_width", g, hw, 2);
    check("vs_rise_x", g, vrise_x, vs_x);
    check("vs_rise_y", g, vrise_y, vs_y);
    check("vs_width", g, vw, vs_w);
  endtask

  initial begin
    vec_t vt[8];
    int   prev_x, prev_y, fall_x, low_n, ticks, t_first, t_second;
    logic prev_hs;
    bit   seen_fall, done, wrapped, found;

    if (H_T0 >= 2048 || V_T0 >= 2048) $fatal(1, "FAIL totals H %0d V %0d", H_T0, V_T0);

    for (int i = 0; i < 5; i++) vt[i] = '{1'b0, 0, 0, 1'b1, 1'b0, 4'h0};
    vt[5] = '{1'b1, 1, 0, 1'b1, 1'b0, 4'h0};
    vt[6] = '{1'b1, 2, 0, 1'b1, 1'b0, 4'hF};
    vt[7] = '{1'b1, 3, 0, 1'b1, 1'b0, 4'hF};

    for (int i = 0; i < 8; i++) begin
      rst = vt[i].rst;
      step();
      check("vec_x", 0, 32'(cx[0]), 32'(vt[i].x));
      check("vec_y", 0, 32'(cy[0]), 32'(vt[i].y));
      check("vec_hs", 0, 32'(hsv[0]), 32'(vt[i].hs));
      check("vec_vs", 0, 32'(vsv[0]), 32'(vt[i].vs));
      check("vec_rgb", 0, 32'({vr[0], vg[0], vb[0]}), 32'({3{vt[i].rgb}}));
    end

    // One full line at default timing: hsync placement/width and the x wrap.
    seen_fall = 0; done = 0; wrapped = 0; fall_x = -1; low_n = 0;
    prev_hs = hsv[0]; prev_x = int'(cx[0]); prev_y = int'(cy[0]);
    for (int i = 0; i < 2 * H_T0 && !(done && wrapped); i++) begin
      step();
      if (prev_x == H_T0 - 1) begin
        wrapped = 1;
        check("x_wrap", 0, 32'(cx[0]), 0);
        check("y_inc", 0, 32'(cy[0]), prev_y + 1);
      end
      if (!seen_fall && prev_hs && !hsv[0]) begin seen_fall = 1; fall_x = int'(cx[0]); end
      if (seen_fall && !done) begin
        if (!hsv[0]) low_n++;
        else done = 1;
      end
      prev_hs = hsv[0]; prev_x = int'(cx[0]); prev_y = int'(cy[0]);
    end
    check("x_wrap_seen", 0, 32'(wrapped), 1);
    check("hs_fall_x", 0, fall_x, 1522);
    check("hs_width", 0, low_n, 152);

    // Mid-frame reset, switching the compositor stand-in while held.
    found = 0;
    for (int i = 0; i < 2 * H_T0 && !found; i++) begin
      if (cx[0] == 11'd700 && cy[0] == 11'd1) found = 1;
      else step();
    end
    check("reach_700_1", 0, 32'(found), 1);
    rst = 1'b0;
    align = 1'b1;
    step();
    check("midrst_x", 0, 32'(cx[0]), 0);
    check("midrst_y", 0, 32'(cy[0]), 0);
    check("midrst_pins", 0, 32'({hsv[0], vsv[0], vr[0]}), 32'({1'b1, 1'b0, 4'h0}));
    rst = 1'b1;
    step();
    check("release_x", 0, 32'(cx[0]), 1);
    check("release_y", 0, 32'(cy[0]), 0);

    // Colour alignment at the blank edges of line 0.
    for (int i = 0; i < H_T0 && !(cx[0] == 11'd0 && cy[0] == 11'd1); i++) begin
      step();
      case (int'(cx[0]))
        2:    check("align_x0", 0, 32'(vr[0]), 32'h0);
        3:    check("align_x1", 0, 32'(vr[0]), 32'h1);
        1441: check("align_x1439", 0, 32'(vr[0]), 32'hF);
        1442: check("align_x1440", 0, 32'(vr[0]), 32'h0);
        default: ;
      endcase
    end

    measure_small(1, 12, 2, 5, 14);
    measure_small(2, 0, 4, 5, 14);

    // Frame tick on the small raster: two pulses over two frames, one frame apart.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (tk[1]) found = 1;
    end
    check("tick_seen", 1, 32'(found), 1);
    ticks = 0; t_first = -1; t_second = -1;
    for (int i = 1; i <= 196; i++) begin
      step();
      if (tk[1]) begin
        ticks++;
        if (t_first < 0) t_first = i;
        else if (t_second < 0) t_second = i;
      end
    end
    check("tick_count", 1, ticks, 2);
    check("tick_period", 1, t_second - t_first, 98);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
